// File: rtl/pixel_filter_engine.sv
// Two-stage per-pixel colour filter with frame-locked filter selection.
// Optional warm filter on code '5' is built when PIXEL_FILTER_WARM_EN is defined.
module pixel_filter_engine #(
    parameter int unsigned THRESH    = 100,
    parameter int unsigned WARM_STEP = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  oper,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic [23:0] out_rgb,
    output logic [7:0]  active_oper
);

    localparam logic [9:0] Thr = 10'(THRESH);

    logic        en;
    logic        take;
    logic        sel_new;
    logic [7:0]  code_d;
    logic [7:0]  in_r, in_g, in_b;
    logic [7:0]  max_d, min_d;
    logic [9:0]  sum_d;

    logic        s1_valid_q, s1_sof_q;
    logic [7:0]  s1_code_q;
    logic [23:0] s1_rgb_q;
    logic [9:0]  s1_sum_q;
    logic [7:0]  s1_max_q, s1_min_q;

    logic        out_valid_q, out_sof_q;
    logic [23:0] out_rgb_q;
    logic [7:0]  active_oper_q;

    logic [9:0]  avg;
    logic [7:0]  desat;
    logic [23:0] filt_d;

    assign en       = out_ready || !out_valid_q;
    assign in_ready = en;
    assign take     = in_valid && en;
    assign sel_new  = in_sof && (oper != 8'h00);
    assign code_d   = sel_new ? oper : active_oper_q;

    assign in_r  = in_rgb[23:16];
    assign in_g  = in_rgb[15:8];
    assign in_b  = in_rgb[7:0];
    assign sum_d = 10'(in_r) + 10'(in_g) + 10'(in_b);

    always_comb begin
        max_d = in_r;
        min_d = in_r;
        if (in_g > max_d) max_d = in_g;
        if (in_b > max_d) max_d = in_b;
        if (in_g < min_d) min_d = in_g;
        if (in_b < min_d) min_d = in_b;
    end

    assign avg   = s1_sum_q / 10'd3;
    assign desat = 8'((9'(s1_max_q) + 9'(s1_min_q)) >> 1);

`ifdef PIXEL_FILTER_WARM_EN
    localparam logic [7:0] Ws = 8'(WARM_STEP);
    logic [8:0] warm_sum;
    logic [7:0] warm_r, warm_b;
    assign warm_sum = 9'(s1_rgb_q[23:16]) + 9'(Ws);
    assign warm_r   = warm_sum[8] ? 8'hFF : warm_sum[7:0];
    assign warm_b   = (s1_rgb_q[7:0] > Ws) ? s1_rgb_q[7:0] - Ws : 8'h00;
`else
    localparam int unsigned unused_warm_step = WARM_STEP;
`endif

    always_comb begin
        filt_d = s1_rgb_q;
        case (s1_code_q)
            8'h31: filt_d = {3{avg[7:0]}};
            8'h32: filt_d = (avg >= Thr) ? 24'hFFFFFF : 24'h000000;
            8'h33: filt_d = ~s1_rgb_q;
            8'h34: filt_d = {3{desat}};
`ifdef PIXEL_FILTER_WARM_EN
            8'h35: filt_d = {warm_r, s1_rgb_q[15:8], warm_b};
`endif
            default: filt_d = s1_rgb_q;
        endcase
    end

    // Both stages freeze together so a stalled output word never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sof_q      <= 1'b0;
            s1_code_q     <= 8'h00;
            s1_rgb_q      <= 24'h0;
            s1_sum_q      <= 10'h0;
            s1_max_q      <= 8'h00;
            s1_min_q      <= 8'h00;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_rgb_q     <= 24'h0;
            active_oper_q <= 8'h00;
        end else begin
            if (take && sel_new) active_oper_q <= oper;
            if (en) begin
                s1_valid_q  <= in_valid;
                out_valid_q <= s1_valid_q;
                if (in_valid) begin
                    s1_sof_q  <= in_sof;
                    s1_code_q <= code_d;
                    s1_rgb_q  <= in_rgb;
                    s1_sum_q  <= sum_d;
                    s1_max_q  <= max_d;
                    s1_min_q  <= min_d;
                end
                if (s1_valid_q) begin
                    out_sof_q <= s1_sof_q;
                    out_rgb_q <= filt_d;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign out_rgb     = out_rgb_q;
    assign active_oper = active_oper_q;

endmodule

// File: tb/tb_pixel_filter_engine.sv
// Bench for pixel_filter_engine: directed steps plus a random stream
// scored against an arithmetic reference model of the filters.
module tb_pixel_filter_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  oper;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [23:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic [23:0] out_rgb;
    logic [7:0]  active_oper;

    always #5 clk = ~clk;

    pixel_filter_engine dut (
        .clk(clk), .rst(rst), .oper(oper),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_rgb(in_rgb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_rgb(out_rgb),
        .active_oper(active_oper)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [23:0] exp_rgb_q[$];
    logic        exp_sof_q[$];
    logic [23:0] got[$];
    logic [7:0]  m_active = 8'h00;
    logic        prev_hold = 1'b0;
    logic [23:0] prev_rgb;
    logic        prev_sof;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [7:0] code,
                                          input logic [23:0] p);
        int r, g, b, s, mx, mn, y;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        s = r + g + b;
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;
        mn = (mn < b) ? mn : b;
        case (code)
            8'h31: begin y = s / 3; return {8'(y), 8'(y), 8'(y)}; end
            8'h32: return (s / 3 >= 100) ? 24'hFFFFFF : 24'h000000;
            8'h33: return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
            8'h34: begin y = (mx + mn) / 2; return {8'(y), 8'(y), 8'(y)}; end
`ifdef PIXEL_FILTER_WARM_EN
            8'h35: return {8'((r + 40 > 255) ? 255 : r + 40), 8'(g),
                           8'((b > 40) ? b - 40 : 0)};
`endif
            default: return p;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic sof, input logic [23:0] rgb,
                       input logic [7:0] op, input logic ordy, output logic acc);
        logic [23:0] e_rgb;
        logic        e_sof;
        in_valid = v; in_sof = sof; in_rgb = rgb; oper = op; out_ready = ordy;
        #1;
        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_rgb", 32'(out_rgb), 32'(prev_rgb));
            chk("hold_sof", 32'(out_sof), 32'(prev_sof));
        end
        if (out_valid && out_ready) begin
            if (exp_rgb_q.size() == 0) begin
                chk("unexpected_out", 32'(exp_rgb_q.size()), 32'd1);
            end else begin
                e_rgb = exp_rgb_q.pop_front();
                e_sof = exp_sof_q.pop_front();
                chk("out_rgb", 32'(out_rgb), 32'(e_rgb));
                chk("out_sof", 32'(out_sof), 32'(e_sof));
            end
            got.push_back(out_rgb);
        end
        prev_hold = out_valid && !out_ready;
        prev_rgb  = out_rgb;
        prev_sof  = out_sof;
        acc = v && in_ready;
        if (acc) begin
            if (sof && op != 8'h00) m_active = op;
            exp_rgb_q.push_back(model(m_active, rgb));
            exp_sof_q.push_back(sof);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic sof, input logic [23:0] rgb,
                        input logic [7:0] op);
        logic acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cyc(1'b1, sof, rgb, op, 1'b1, acc);
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 24'h0, 8'h00, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_rgb_q.delete();
        exp_sof_q.delete();
        m_active  = 8'h00;
        prev_hold = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic [23:0] px[8];
        logic [7:0]  opt[10];
        logic        pend, psof;
        logic [23:0] prgb;
        int          idx;

        opt = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h41};
        rst = 1'b1; oper = 8'h00; in_valid = 1'b0; in_sof = 1'b0;
        in_rgb = 24'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sof", 32'(out_sof), 32'd0);
        chk("rst_out_rgb", 32'(out_rgb), 32'd0);
        chk("rst_active", 32'(active_oper), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // gray and two-cycle latency
        cyc(1'b1, 1'b1, 24'h1E3C5A, 8'h31, 1'b1, acc);
        chk("t1_acc", 32'(acc), 32'd1);
        chk("t1_active", 32'(active_oper), 32'h31);
        chk("t1_lat1_valid", 32'(out_valid), 32'd0);
        idle(1);
        chk("t1_lat2_valid", 32'(out_valid), 32'd1);
        chk("t1_rgb", 32'(out_rgb), 32'h3C3C3C);
        chk("t1_sof", 32'(out_sof), 32'd1);
        idle(2);

        // binary threshold edge
        send(1'b1, 24'h646464, 8'h32);
        send(1'b0, 24'h636464, 8'h32);
        idle(3);
        chk("t2_at_thresh", 32'(got[got.size()-2]), 32'hFFFFFF);
        chk("t2_below", 32'(got[got.size()-1]), 32'h000000);

        // negative, mid-frame change ignored, sticky zero, desaturate
        send(1'b1, 24'h00FF10, 8'h33);
        send(1'b0, 24'h00FF10, 8'h34);
        idle(3);
        chk("t3_neg", 32'(got[got.size()-2]), 32'hFF00EF);
        chk("t3_midframe", 32'(got[got.size()-1]), 32'hFF00EF);
        chk("t3_active", 32'(active_oper), 32'h33);
        send(1'b1, 24'h00FF10, 8'h00);
        idle(3);
        chk("t3_sticky", 32'(got[got.size()-1]), 32'hFF00EF);
        chk("t3_sticky_act", 32'(active_oper), 32'h33);
        send(1'b1, 24'h00FF10, 8'h34);
        idle(3);
        chk("t3_desat", 32'(got[got.size()-1]), 32'h7F7F7F);
        chk("t3_active4", 32'(active_oper), 32'h34);

        // output stall with a continuous source
        for (int i = 0; i < 8; i++) px[i] = 24'($urandom);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                out_ready = 1'b0;
                #1;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
            cyc(idx < 8, idx == 0, (idx < 8) ? px[idx] : 24'h0, 8'h33,
                c >= 5, acc);
            if (acc) idx++;
        end
        idle(4);
        chk("stall_count", 32'(idx), 32'd8);
        chk("stall_drain", 32'(exp_rgb_q.size()), 32'd0);

        // warm filter
        send(1'b1, 24'hF01020, 8'h35);
        idle(3);
        chk("t5_active", 32'(active_oper), 32'h35);
`ifdef PIXEL_FILTER_WARM_EN
        chk("t5_warm", 32'(got[got.size()-1]), 32'hFF1000);
`else
        chk("t5_warm", 32'(got[got.size()-1]), 32'hF01020);
`endif

        // reset with two pixels in flight
        send(1'b1, 24'h102030, 8'h31);
        send(1'b0, 24'h405060, 8'h31);
        do_reset();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_active", 32'(active_oper), 32'd0);
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        send(1'b0, 24'h123456, 8'h33);
        idle(3);
        chk("t6_pass", 32'(got[got.size()-1]), 32'h123456);
        chk("t6_drain", 32'(exp_rgb_q.size()), 32'd0);

        // random stream with random backpressure
        pend = 1'b0; psof = 1'b0; prgb = 24'h0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && ($urandom % 4) != 0) begin
                pend = 1'b1;
                psof = (($urandom % 6) == 0);
                prgb = 24'($urandom);
            end
            cyc(pend, psof, prgb, opt[$urandom % 10], ($urandom % 4) != 0, acc);
            if (acc) pend = 1'b0;
        end
        idle(5);
        chk("rand_drain", 32'(exp_rgb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
